rf_arbiter: RTL and testbench

RF_ARBITER -- requirements
Module: rf_arbiter

---
 rtl/rf_arbiter.sv | 104 ++++++++++
 tb/tb_rf_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register file.
// Optional: define RF_ARB_R0_PROTECT_EN to make register 0 write-protected.
module rf_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_req,
   input  logic              a_wr,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_wr,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wAddr,
   output logic [ADDR_W-1:0] rf_rAddr,
   output logic [DATA_W-1:0] rf_wData,
   input  logic [DATA_W-1:0] rf_rData,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t            state;
   state_t            stateNxt;
   logic              grant;
   logic              pickB;
   logic              ptrB;
   logic              gntB;
   logic              latWr;
   logic [ADDR_W-1:0] latAddr;
   logic [DATA_W-1:0] latData;
   logic              wrBlock;

   always_comb begin
      stateNxt = state;
      grant    = 1'b0;
      pickB    = b_req & (~a_req | ptrB);
      unique case (state)
         IDLE: begin
            if (a_req | b_req) begin
               grant    = 1'b1;
               stateNxt = ACCESS;
            end
         end
         ACCESS:  stateNxt = DONE;
         DONE:    stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         ptrB    <= 1'b0;
         gntB    <= 1'b0;
         latWr   <= 1'b0;
         latAddr <= '0;
         latData <= '0;
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         state <= stateNxt;
         if (grant) begin
            gntB    <= pickB;
            latWr   <= pickB ? b_wr    : a_wr;
            latAddr <= pickB ? b_addr  : a_addr;
            latData <= pickB ? b_wdata : a_wdata;
         end
         if (state == ACCESS && !latWr) begin
            if (gntB) b_rdata <= rf_rData;
            else      a_rdata <= rf_rData;
         end
         // Loser of this round gets priority on the next tie
         if (state == DONE) ptrB <= ~gntB;
      end
   end

`ifdef RF_ARB_R0_PROTECT_EN
   assign wrBlock = (latAddr == '0);
`else
   assign wrBlock = 1'b0;
`endif

   assign rf_we    = (state == ACCESS) & latWr & ~wrBlock;
   assign rf_wAddr = latAddr;
   assign rf_rAddr = latAddr;
   assign rf_wData = latData;
   assign a_ack    = (state == DONE) & ~gntB;
   assign b_ack    = (state == DONE) & gntB;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_rf_arbiter.sv
// Self-checking bench for rf_arbiter: directed scenarios plus random traffic
// against a transaction-level model. Honours RF_ARB_R0_PROTECT_EN.
`timescale 1ns/1ps
module tb_rf_arbiter;
   localparam int DW = 32;
   localparam int AW = 3;
`ifdef RF_ARB_R0_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          a_req, b_req, a_wr, b_wr;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          a_ack, b_ack;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          rf_we;
   logic [AW-1:0] rf_wAddr, rf_rAddr;
   logic [DW-1:0] rf_wData, rf_rData;
   logic          busy;
   logic [DW-1:0] rf [8];
   int            total = 0;
   int            bad = 0;

   always #5 clk = ~clk;

   // External register file; preloads a pattern while reset is held across an edge
   always @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) rf[i] <= DW'(32'hA0 + i);
      end else if (rf_we) begin
         rf[rf_wAddr] <= rf_wData;
      end
   end
   assign rf_rData = rf[rf_rAddr];

   rf_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .rf_we(rf_we), .rf_wAddr(rf_wAddr), .rf_rAddr(rf_rAddr),
      .rf_wData(rf_wData), .rf_rData(rf_rData), .busy(busy)
   );

   task automatic setA(input logic r, input logic w,
                       input logic [AW-1:0] ad, input logic [DW-1:0] d);
      a_req = r; a_wr = w; a_addr = ad; a_wdata = d;
   endtask

   task automatic setB(input logic r, input logic w,
                       input logic [AW-1:0] ad, input logic [DW-1:0] d);
      b_req = r; b_wr = w; b_addr = ad; b_wdata = d;
   endtask

   // Single uncontended transaction; starts and ends on an IDLE negedge
   task automatic runOne(input logic useB, input logic w,
                         input logic [AW-1:0] ad, input logic [DW-1:0] d);
      if (useB) setB(1'b1, w, ad, d);
      else      setA(1'b1, w, ad, d);
      repeat (2) @(negedge clk);
      if (useB) b_req = 1'b0;
      else      a_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      setA(0, 0, '0, '0);
      setB(0, 0, '0, '0);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({a_ack, b_ack, rf_we, busy} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_ctl got=%b want=0000", {a_ack, b_ack, rf_we, busy});
      end
      total++;
      if (a_rdata !== '0 || b_rdata !== '0) begin
         bad++;
         $display("FAIL reset_rdata got=%h/%h want=0/0", a_rdata, b_rdata);
      end
      total++;
      if (rf_wAddr !== '0 || rf_rAddr !== '0 || rf_wData !== '0) begin
         bad++;
         $display("FAIL reset_rf got=%h/%h/%h want=0", rf_wAddr, rf_rAddr, rf_wData);
      end
      reset_n = 1'b1;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_busy got=%b want=0", busy);
      end
   endtask

   task automatic test_write;
      setA(1, 1, 3'd1, 32'h11);
      @(negedge clk);
      total++;
      if ({rf_we, rf_wAddr, rf_wData, busy, a_ack} !== {1'b1, 3'd1, 32'h11, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL wr_access got we=%b a=%h d=%h busy=%b ack=%b want 1/1/11/1/0",
                  rf_we, rf_wAddr, rf_wData, busy, a_ack);
      end
      a_addr = 3'd7;
      a_wdata = 32'hDEADBEEF;
      @(negedge clk);
      total++;
      if ({a_ack, b_ack, rf_we, rf_wAddr} !== {1'b1, 1'b0, 1'b0, 3'd1}) begin
         bad++;
         $display("FAIL wr_done got ack=%b%b we=%b a=%h want 10/0/1",
                  a_ack, b_ack, rf_we, rf_wAddr);
      end
      a_req = 1'b0;
      @(negedge clk);
      total++;
      if (a_ack !== 1'b0 || busy !== 1'b0 || rf[1] !== 32'h11 || rf[7] !== 32'hA7) begin
         bad++;
         $display("FAIL wr_after got ack=%b busy=%b rf1=%h rf7=%h want 0/0/11/a7",
                  a_ack, busy, rf[1], rf[7]);
      end
   endtask

   task automatic test_round_robin;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      setA(1, 1, 3'd2, 32'h22);
      setB(1, 1, 3'd3, 32'h33);
      @(negedge clk);
      total++;
      if ({rf_we, rf_wAddr, rf_wData} !== {1'b1, 3'd2, 32'h22}) begin
         bad++;
         $display("FAIL rr1_first got we=%b a=%h d=%h want 1/2/22", rf_we, rf_wAddr, rf_wData);
      end
      @(negedge clk);
      total++;
      if ({a_ack, b_ack} !== 2'b10) begin
         bad++;
         $display("FAIL rr1_ackA got=%b%b want=10", a_ack, b_ack);
      end
      a_req = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, a_ack, b_ack} !== 3'b000) begin
         bad++;
         $display("FAIL rr1_gap got=%b want=000", {busy, a_ack, b_ack});
      end
      @(negedge clk);
      total++;
      if ({rf_we, rf_wAddr, rf_wData} !== {1'b1, 3'd3, 32'h33}) begin
         bad++;
         $display("FAIL rr1_second got we=%b a=%h d=%h want 1/3/33", rf_we, rf_wAddr, rf_wData);
      end
      @(negedge clk);
      total++;
      if ({a_ack, b_ack} !== 2'b01) begin
         bad++;
         $display("FAIL rr1_ackB got=%b%b want=01", a_ack, b_ack);
      end
      b_req = 1'b0;
      @(negedge clk);
      runOne(1'b0, 1'b1, 3'd7, 32'h77);
      setA(1, 1, 3'd2, 32'h222);
      setB(1, 1, 3'd3, 32'h333);
      @(negedge clk);
      total++;
      if ({rf_we, rf_wAddr, rf_wData} !== {1'b1, 3'd3, 32'h333}) begin
         bad++;
         $display("FAIL rr2_first got we=%b a=%h d=%h want 1/3/333", rf_we, rf_wAddr, rf_wData);
      end
      @(negedge clk);
      total++;
      if ({a_ack, b_ack} !== 2'b01) begin
         bad++;
         $display("FAIL rr2_ackB got=%b%b want=01", a_ack, b_ack);
      end
      b_req = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({rf_we, rf_wAddr, rf_wData} !== {1'b1, 3'd2, 32'h222}) begin
         bad++;
         $display("FAIL rr2_second got we=%b a=%h d=%h want 1/2/222", rf_we, rf_wAddr, rf_wData);
      end
      @(negedge clk);
      total++;
      if ({a_ack, b_ack} !== 2'b10) begin
         bad++;
         $display("FAIL rr2_ackA got=%b%b want=10", a_ack, b_ack);
      end
      a_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_read;
      runOne(1'b0, 1'b1, 3'd5, 32'h55);
      setB(1, 0, 3'd5, '0);
      repeat (2) @(negedge clk);
      total++;
      if (b_ack !== 1'b1 || b_rdata !== 32'h55 || a_rdata !== '0) begin
         bad++;
         $display("FAIL rd_b got ack=%b rd=%h ard=%h want 1/55/0", b_ack, b_rdata, a_rdata);
      end
      b_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      runOne(1'b1, 1'b1, 3'd5, 32'h5A);
      setA(1, 0, 3'd6, '0);
      @(negedge clk);
      setB(1, 0, 3'd5, '0);
      @(negedge clk);
      total++;
      if (a_ack !== 1'b1 || b_ack !== 1'b0 || a_rdata !== 32'hA6) begin
         bad++;
         $display("FAIL wait_a got ack=%b%b rd=%h want 10/a6", a_ack, b_ack, a_rdata);
      end
      a_req = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL wait_gap got busy=%b want=0", busy);
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || rf_rAddr !== 3'd5) begin
         bad++;
         $display("FAIL wait_grantB got busy=%b ra=%h want 1/5", busy, rf_rAddr);
      end
      @(negedge clk);
      total++;
      if (b_ack !== 1'b1 || b_rdata !== 32'h5A || a_rdata !== 32'hA6) begin
         bad++;
         $display("FAIL wait_b got ack=%b rd=%h ard=%h want 1/5a/a6", b_ack, b_rdata, a_rdata);
      end
      b_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_abort;
      runOne(1'b0, 1'b1, 3'd4, 32'h40);
      setA(1, 1, 3'd4, 32'h44);
      @(negedge clk);
      total++;
      if (rf_we !== 1'b1) begin
         bad++;
         $display("FAIL abort_pre got we=%b want=1", rf_we);
      end
      reset_n = 1'b0;
      #1;
      total++;
      if ({rf_we, busy, a_ack, b_ack} !== 4'b0000 || rf_wAddr !== '0 || rf_wData !== '0) begin
         bad++;
         $display("FAIL abort_now got ctl=%b a=%h d=%h want 0000/0/0",
                  {rf_we, busy, a_ack, b_ack}, rf_wAddr, rf_wData);
      end
      total++;
      if (a_rdata !== '0 || b_rdata !== '0) begin
         bad++;
         $display("FAIL abort_rdata got=%h/%h want=0/0", a_rdata, b_rdata);
      end
      a_req = 1'b0;
      #1;
      reset_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         total++;
         if (a_ack !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_noack got ack=%b busy=%b want 0/0", a_ack, busy);
         end
      end
      setB(1, 0, 3'd4, '0);
      repeat (2) @(negedge clk);
      total++;
      if (b_ack !== 1'b1 || b_rdata !== 32'h40) begin
         bad++;
         $display("FAIL abort_readback got ack=%b rd=%h want 1/40", b_ack, b_rdata);
      end
      b_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_r0;
      logic [DW-1:0] expR0;
      expR0 = PROT ? 32'hA0 : 32'hFF;
      setA(1, 1, 3'd0, 32'hFF);
      @(negedge clk);
      total++;
      if (rf_we !== !PROT || busy !== 1'b1) begin
         bad++;
         $display("FAIL r0_access got we=%b busy=%b want %b/1", rf_we, busy, !PROT);
      end
      @(negedge clk);
      total++;
      if (a_ack !== 1'b1 || rf_we !== 1'b0) begin
         bad++;
         $display("FAIL r0_ack got ack=%b we=%b want 1/0", a_ack, rf_we);
      end
      a_req = 1'b0;
      @(negedge clk);
      setB(1, 0, 3'd0, '0);
      repeat (2) @(negedge clk);
      total++;
      if (b_ack !== 1'b1 || b_rdata !== expR0) begin
         bad++;
         $display("FAIL r0_readback got ack=%b rd=%h want 1/%h", b_ack, b_rdata, expR0);
      end
      b_req = 1'b0;
      @(negedge clk);
   endtask

   // Random two-requester traffic against a transaction-level model
   task automatic test_random;
      logic [DW-1:0] refMem [8];
      logic [DW-1:0] rdA, rdB, pend, gData;
      logic [AW-1:0] gAddr;
      int            g, nextG;
      bit            lastB, gB, gWr, aDrop, bDrop;
      bit            expBusy, expWe, expAckA, expAckB;
      setA(0, 0, '0, '0);
      setB(0, 0, '0, '0);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) refMem[i] = DW'(32'hA0 + i);
      rdA = '0; rdB = '0; pend = '0; gData = '0; gAddr = '0;
      g = -10; nextG = 0; lastB = 1'b1; gB = 1'b0; gWr = 1'b0;
      aDrop = 1'b0; bDrop = 1'b0;
      for (int c = 1; c <= 600; c++) begin
         @(negedge clk);
         if (c == g + 1 && !gWr) begin
            if (gB) rdB = pend;
            else    rdA = pend;
         end
         if (c >= nextG && (a_req || b_req)) begin
            gB    = b_req && (!a_req || !lastB);
            lastB = gB;
            g     = c;
            nextG = c + 3;
            gWr   = gB ? b_wr : a_wr;
            gAddr = gB ? b_addr : a_addr;
            gData = gB ? b_wdata : a_wdata;
            if (gWr && !(PROT && gAddr == '0)) refMem[gAddr] = gData;
            else if (!gWr) pend = refMem[gAddr];
         end
         expBusy = (c == g) || (c == g + 1);
         expWe   = (c == g) && gWr && !(PROT && gAddr == '0);
         expAckA = (c == g + 1) && !gB;
         expAckB = (c == g + 1) && gB;
         total++;
         if (busy !== expBusy) begin
            bad++;
            $display("FAIL rnd_busy c=%0d got=%b want=%b", c, busy, expBusy);
         end
         total++;
         if (rf_we !== expWe) begin
            bad++;
            $display("FAIL rnd_we c=%0d got=%b want=%b", c, rf_we, expWe);
         end
         total++;
         if ({a_ack, b_ack} !== {expAckA, expAckB}) begin
            bad++;
            $display("FAIL rnd_ack c=%0d got=%b%b want=%b%b", c, a_ack, b_ack, expAckA, expAckB);
         end
         total++;
         if (a_rdata !== rdA || b_rdata !== rdB) begin
            bad++;
            $display("FAIL rnd_rdata c=%0d got=%h/%h want=%h/%h", c, a_rdata, b_rdata, rdA, rdB);
         end
         total++;
         if (rf_wAddr !== gAddr || rf_rAddr !== gAddr || rf_wData !== gData) begin
            bad++;
            $display("FAIL rnd_rfbus c=%0d got=%h/%h/%h want=%h/%h/%h",
                     c, rf_wAddr, rf_rAddr, rf_wData, gAddr, gAddr, gData);
         end
         if (c == g) begin
            if (gB) begin b_addr = AW'($urandom); b_wdata = $urandom; end
            else    begin a_addr = AW'($urandom); a_wdata = $urandom; end
         end
         if (aDrop) begin
            a_req = 1'b0; aDrop = 1'b0;
         end else if (expAckA) begin
            aDrop = 1'b1;
         end else if (!a_req && $urandom_range(0, 2) == 0) begin
            setA(1'b1, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
         end
         if (bDrop) begin
            b_req = 1'b0; bDrop = 1'b0;
         end else if (expAckB) begin
            bDrop = 1'b1;
         end else if (!b_req && $urandom_range(0, 2) == 0) begin
            setB(1'b1, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
         end
      end
   endtask

   initial begin
      test_reset;
      test_write;
      test_round_robin;
      test_read;
      test_back_to_back;
      test_abort;
      test_r0;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
